// File: rtl/fifo_master_regif.sv
// Register-mapped bus slave in front of a DATA_W x DEPTH synchronous FIFO
// with sticky W1C error flags, level/threshold status, flush and interrupt.
module fifo_master_regif #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [2:0]        addr,
  input  logic              write,
  input  logic              read,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              resp,
  output logic              irq
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  thresh_q, thresh_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              irq_en_q, irq_en_d;
  logic              irq_q, irq_d;
  logic              resp_q, resp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic wr_acc, rd_acc;
  logic empty, full, thr_hit, thr_hit_d;
  logic push, pop, flush;
  logic ovf_set, udf_set, ovf_clr, udf_clr;

  always_comb begin
    // write has priority when both strobes are raised
    wr_acc  = enable & write;
    rd_acc  = enable & read & ~write;
    resp_d  = wr_acc | rd_acc;

    empty   = (count_q == '0);
    full    = (count_q == CNT_W'(DEPTH));
    thr_hit = (count_q >= thresh_q);

    push    = wr_acc & (addr == 3'd0) & ~full;
    pop     = rd_acc & (addr == 3'd0) & ~empty;
    ovf_set = wr_acc & (addr == 3'd0) & full;
    udf_set = rd_acc & (addr == 3'd0) & empty;
    ovf_clr = wr_acc & (addr == 3'd1) & wdata[2];
    udf_clr = wr_acc & (addr == 3'd1) & wdata[3];
    flush   = wr_acc & (addr == 3'd4) & wdata[0];

    ovf_d   = ovf_set | (ovf_q & ~ovf_clr);
    udf_d   = udf_set | (udf_q & ~udf_clr);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d  = count_q + CNT_W'(1);
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = count_q - CNT_W'(1);
    end

    thresh_d = thresh_q;
    if (wr_acc && addr == 3'd3) thresh_d = wdata[CNT_W-1:0];

    irq_en_d = irq_en_q;
    if (wr_acc && addr == 3'd4) irq_en_d = wdata[1];

    // irq tracks the post-edge state so it lands one cycle after its cause
    thr_hit_d = (count_d >= thresh_d);
    irq_d     = irq_en_d & (ovf_d | udf_d | thr_hit_d);

    rdata_d = rdata_q;
    if (rd_acc) begin
      case (addr)
        3'd0:    rdata_d = pop ? mem_q[rd_ptr_q] : '0;
        3'd1:    rdata_d = DATA_W'({thr_hit, udf_q, ovf_q, full, empty});
        3'd2:    rdata_d = DATA_W'(count_q);
        3'd3:    rdata_d = DATA_W'(thresh_q);
        3'd4:    rdata_d = DATA_W'({irq_en_q, 1'b0});
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      thresh_q <= CNT_W'(DEPTH / 2);
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      resp_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      thresh_q <= thresh_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      resp_q   <= resp_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign resp  = resp_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_fifo_master_regif.sv
// Scoreboard bench for fifo_master_regif: queue-based FIFO model,
// directed register scenarios, randomized traffic and async reset.
module tb_fifo_master_regif;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [2:0]    addr = '0;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          resp;
  logic          irq;

  always #5 clk = ~clk;

  fifo_master_regif #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .addr(addr),
    .write(write), .read(read), .wdata(wdata),
    .rdata(rdata), .resp(resp), .irq(irq)
  );

  typedef struct {
    bit            is_rd;
    logic [DW-1:0] data;
    bit            irq;
  } exp_t;

  exp_t sb[$];
  int   mq[$];
  bit   m_ovf, m_udf, m_ien;
  int   m_thr;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_irq();
    return m_ien && (m_ovf || m_udf || mq.size() >= m_thr);
  endfunction

  task automatic m_reset();
    mq.delete();
    m_ovf = 0;
    m_udf = 0;
    m_ien = 0;
    m_thr = DEPTH / 2;
  endtask

  // Drive one bus cycle, update the model, queue the expected response.
  task automatic op(bit en, bit w, bit r, logic [2:0] a, logic [DW-1:0] d);
    exp_t e;
    bit   acc;
    acc = en && (w || r);
    enable = en; write = w; read = r; addr = a; wdata = d;
    e.is_rd = acc && !w;
    e.data  = '0;
    if (acc && w) begin
      case (a)
        3'd0: if (mq.size() == DEPTH) m_ovf = 1; else mq.push_back(int'(d));
        3'd1: begin
          if (d[2]) m_ovf = 0;
          if (d[3]) m_udf = 0;
        end
        3'd3: m_thr = int'(d) % (2 * DEPTH);
        3'd4: begin
          if (d[0]) mq.delete();
          m_ien = d[1];
        end
        default: ;
      endcase
    end else if (acc) begin
      case (a)
        3'd0: if (mq.size() == 0) m_udf = 1; else e.data = DW'(mq.pop_front());
        3'd1: e.data = DW'({mq.size() >= m_thr, m_udf, m_ovf,
                            mq.size() == DEPTH, mq.size() == 0});
        3'd2: e.data = DW'(mq.size());
        3'd3: e.data = DW'(m_thr);
        3'd4: e.data = DW'({m_ien, 1'b0});
        default: e.data = '0;
      endcase
    end
    e.irq = m_irq();
    @(posedge clk);
    #1;
    if (acc) sb.push_back(e);
    enable = 0; write = 0; read = 0;
  endtask

  task automatic wr(logic [2:0] a, logic [DW-1:0] d);
    op(1, 1, 0, a, d);
  endtask

  task automatic rd(logic [2:0] a);
    op(1, 0, 1, a, '0);
  endtask

  task automatic idle();
    op(0, 1'($urandom), 1'($urandom), 3'($urandom), DW'($urandom));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() == 0) begin
        if (resp) chk("spurious_resp", resp, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp", resp, 1);
        if (e.is_rd) chk("rdata", rdata, e.data);
        chk("irq", irq, e.irq);
      end
    end
  end

  initial begin
    m_reset();
    #2;
    chk("rst_rdata", rdata, 0);
    chk("rst_resp", resp, 0);
    chk("rst_irq", irq, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    rd(1); rd(2); rd(3);

    for (int i = 0; i < 16; i++) wr(0, DW'(8'h11 + i));
    rd(1);
    wr(0, 8'hAA);
    rd(1);
    for (int i = 0; i < 16; i++) rd(0);
    rd(1);
    wr(1, 8'h04);

    for (int i = 0; i < 3; i++) wr(0, DW'($urandom));
    for (int i = 0; i < 37; i++) begin
      wr(0, DW'($urandom));
      rd(0);
      if (i % 4 == 0) rd(2);
    end
    for (int i = 0; i < 3; i++) rd(0);

    rd(0); rd(1);
    wr(1, 8'h04); rd(1);
    wr(1, 8'h08); rd(1);

    wr(4, 8'h02);
    wr(3, 8'h04);
    for (int i = 0; i < 4; i++) wr(0, DW'(8'h40 + i));
    idle();
    wr(4, 8'h03);
    idle();
    rd(2); rd(4);

    for (int i = 0; i < 400; i++) begin
      int k;
      logic [2:0] a;
      k = $urandom_range(0, 9);
      a = (k > 7) ? 3'd0 : 3'(k);
      k = $urandom_range(0, 11);
      if (k == 0) idle();
      else if (k == 1) op(1, 1, 1, a, DW'($urandom));
      else if (k < 6) begin
        if (a == 3'd4 && ($urandom_range(0, 3) != 0))
          wr(a, DW'($urandom) & 8'hFE);
        else
          wr(a, DW'($urandom));
      end else rd(a);
    end

    wr(1, 8'h0C);
    wr(4, 8'h03);
    wr(3, 8'h01);
    for (int i = 0; i < 5; i++) wr(0, DW'(8'h60 + i));
    rst_n = 0;
    #1;
    chk("async_rdata", rdata, 0);
    chk("async_resp", resp, 0);
    chk("async_irq", irq, 0);
    sb.delete();
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    rd(2); rd(3); rd(1);
    repeat (3) idle();

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
